// File: rtl/alu_seq.sv
// alu_seq
//    Multi-cycle unsigned integer ALU with valid/ready handshakes on both sides.
//    ADD, SUB, AND, OR, XOR, NOT and DIV-by-zero complete one cycle after accept.
//    MUL (shift-add) and DIV (restoring) iterate for WIDTH cycles.
//    Result and NZCV flags are registered and held until the consumer takes them.
//
// Ports
//    clk        in   1      system clock, rising edge
//    rst        in   1      asynchronous, active-high reset
//    in_valid   in   1      operands/op presented
//    in_ready   out  1      ALU can accept an op (IDLE only)
//    op         in   3      000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 NOT
//    a, b       in   WIDTH  operands (b ignored for NOT)
//    out_valid  out  1      result/flags valid (DONE only)
//    out_ready  in   1      consumer takes result
//    result     out  WIDTH  registered result
//    flags      out  4      {N,Z,C,V}, registered with result
//
// Build option
//    ALU_FAST_MUL_EN : MUL is a single-cycle multiply registered straight into DONE.
//                      Undefined: iterative shift-add MUL, no multiplier inferred.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an op
// BUSY  | one MUL/DIV iteration per cycle, counter running down
// DONE  | out_valid=1, result/flags held until out_ready

module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_NOT = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_n;

   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [CNT_W-1:0] cnt;

   logic             iterate;
   logic [WIDTH-1:0] quick_res;
   logic             quick_c;
   logic             quick_v;
   logic [WIDTH:0]   add_full;
   logic [WIDTH-1:0] sub_res;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_r;
   logic [WIDTH:0]   div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;
   logic             step_c;

`ifdef ALU_FAST_MUL_EN
   logic [2*WIDTH-1:0] prod;
   assign prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   assign iterate = (op == OP_DIV) && (b != '0);
`else
   assign iterate = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
`endif

   // Single-cycle results, computed from the live inputs and captured on accept.
   always_comb begin
      add_full  = {1'b0, a} + {1'b0, b};
      sub_res   = a - b;
      quick_res = '0;
      quick_c   = 1'b0;
      quick_v   = 1'b0;
      case (op)
         OP_ADD: begin
            quick_res = add_full[WIDTH-1:0];
            quick_c   = add_full[WIDTH];
            quick_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            quick_res = sub_res;
            quick_c   = (a >= b);
            quick_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
         end
`ifdef ALU_FAST_MUL_EN
         OP_MUL: begin
            quick_res = prod[WIDTH-1:0];
            quick_c   = |prod[2*WIDTH-1:WIDTH];
         end
`endif
         // Only reaches result when b==0; a non-zero divisor takes the iterative path.
         OP_DIV: begin
            quick_res = '1;
            quick_v   = 1'b1;
         end
         OP_AND:  quick_res = a & b;
         OP_OR:   quick_res = a | b;
         OP_XOR:  quick_res = a ^ b;
         OP_NOT:  quick_res = ~a;
         default: quick_res = '0;
      endcase
   end

   // One iteration step. MUL: {hi,lo} holds partial product with the multiplier
   // shifting out of lo. DIV: hi is the running remainder, lo shifts the dividend
   // out and the quotient bits in.
   always_comb begin
      mul_sum  = lo[0] ? ({1'b0, hi} + {1'b0, a_q}) : {1'b0, hi};
      div_r    = {hi, lo[WIDTH-1]};
      div_ge   = (div_r >= {1'b0, b_q});
      div_diff = div_r - {1'b0, b_q};
      if (op_q == OP_MUL) begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], lo[WIDTH-1:1]};
         step_c  = |mul_sum[WIDTH:1];
      end else begin
         step_hi = div_ge ? div_diff[WIDTH-1:0] : div_r[WIDTH-1:0];
         step_lo = {lo[WIDTH-2:0], div_ge};
         step_c  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Handshake outputs depend on state only, so no input reaches an output combinationally.
   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_n = iterate ? S_BUSY : S_DONE;
            end
         end
         S_BUSY: begin
            if (cnt == CNT_W'(1)) begin
               state_n = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
         result <= '0;
         flags  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_q <= op;
                  a_q  <= a;
                  b_q  <= b;
                  cnt  <= CNT_W'(WIDTH);
                  hi   <= '0;
                  lo   <= (op == OP_MUL) ? b : a;
                  if (!iterate) begin
                     result <= quick_res;
                     flags  <= {quick_res[WIDTH-1], quick_res == '0, quick_c, quick_v};
                  end
               end
            end
            S_BUSY: begin
               hi  <= step_hi;
               lo  <= step_lo;
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  result <= step_lo;
                  flags  <= {step_lo[WIDTH-1], step_lo == '0, step_c, 1'b0};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
module tb_alu_seq #(
   parameter int WIDTH = 32
);

`ifdef ALU_FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   localparam logic [2:0] ADD = 3'd0;
   localparam logic [2:0] SUB = 3'd1;
   localparam logic [2:0] MUL = 3'd2;
   localparam logic [2:0] DIV = 3'd3;
   localparam logic [2:0] XOR = 3'd6;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [3:0]       flags;

   int checks = 0;
   int errors = 0;

   alu_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic modulo 2^WIDTH, signed overflow from range checks.
   function automatic void model(input logic [2:0] o, input logic [WIDTH-1:0] xa,
                                 input logic [WIDTH-1:0] ya,
                                 output logic [WIDTH-1:0] r, output logic [3:0] f);
      longint unsigned m, x, y, full;
      longint          sx, sy, ss, lim;
      logic            c, v;
      m    = 64'd1 << WIDTH;
      x    = 64'(xa);
      y    = 64'(ya);
      lim  = longint'(m >> 1);
      sx   = (x >= (m >> 1)) ? longint'(x) - longint'(m) : longint'(x);
      sy   = (y >= (m >> 1)) ? longint'(y) - longint'(m) : longint'(y);
      ss   = 0;
      c    = 1'b0;
      v    = 1'b0;
      full = 0;
      case (o)
         3'd0: begin full = x + y; c = (full >= m); ss = sx + sy; v = (ss >= lim) || (ss < -lim); end
         3'd1: begin full = x + m - y; c = (x >= y); ss = sx - sy; v = (ss >= lim) || (ss < -lim); end
         3'd2: begin full = x * y; c = ((full / m) != 0); end
         3'd3: begin
            if (y == 0) begin full = m - 1; v = 1'b1; end
            else full = x / y;
         end
         3'd4: full = x & y;
         3'd5: full = x | y;
         3'd6: full = x ^ y;
         default: full = (m - 1) - x;
      endcase
      full = full % m;
      r = full[WIDTH-1:0];
      f = {full >= (m >> 1), full == 0, c, v};
   endfunction

   // Clock edges from the accept edge until out_valid is seen.
   function automatic int exp_edges(input logic [2:0] o, input logic [WIDTH-1:0] y);
      if ((o == MUL && !FAST) || (o == DIV && y != '0)) return WIDTH;
      return 0;
   endfunction

   // Presents one op from IDLE, returns edges to out_valid (-1 on timeout) and the output.
   task automatic run_op(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         output int lat, output logic [WIDTH-1:0] r, output logic [3:0] f);
      @(negedge clk);
      in_valid = 1'b1;
      op = o;
      a  = x;
      b  = y;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op = 3'($urandom);
      a  = WIDTH'($urandom);
      b  = WIDTH'($urandom);
      lat = 0;
      while (!out_valid && lat < 2 * WIDTH + 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!out_valid) lat = -1;
      r = result;
      f = flags;
   endtask

   task automatic release_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op        = '0;
      a         = '0;
      b         = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++;
      if (result !== '0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
      checks++;
      if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", flags); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_corner_cases();
      logic [2:0]       t_op[7];
      logic [WIDTH-1:0] t_x[7], t_y[7], t_r[7];
      logic [3:0]       t_f[7];
      logic [WIDTH-1:0] ones, msb, maxpos, half, r;
      logic [3:0]       f;
      int               lat;
      ones   = '1;
      maxpos = ones >> 1;
      msb    = ~maxpos;
      half   = WIDTH'(1) << (WIDTH / 2);
      t_op[0] = ADD; t_x[0] = ones;          t_y[0] = WIDTH'(1); t_r[0] = '0;           t_f[0] = 4'b0110;
      t_op[1] = ADD; t_x[1] = maxpos;        t_y[1] = WIDTH'(1); t_r[1] = msb;          t_f[1] = 4'b1001;
      t_op[2] = SUB; t_x[2] = WIDTH'(5);     t_y[2] = WIDTH'(7); t_r[2] = ones - 1'b1;  t_f[2] = 4'b1000;
      t_op[3] = SUB; t_x[3] = WIDTH'(7);     t_y[3] = WIDTH'(7); t_r[3] = '0;           t_f[3] = 4'b0110;
      t_op[4] = MUL; t_x[4] = half;          t_y[4] = half;      t_r[4] = '0;           t_f[4] = 4'b0110;
      t_op[5] = DIV; t_x[5] = WIDTH'(100);   t_y[5] = WIDTH'(7); t_r[5] = WIDTH'(14);   t_f[5] = 4'b0000;
      t_op[6] = DIV; t_x[6] = WIDTH'(9);     t_y[6] = '0;        t_r[6] = ones;         t_f[6] = 4'b1001;
      for (int i = 0; i < 7; i++) begin
         run_op(t_op[i], t_x[i], t_y[i], lat, r, f);
         checks++;
         if (lat != exp_edges(t_op[i], t_y[i])) begin
            errors++;
            $display("FAIL corner%0d_latency got %0d exp %0d", i, lat, exp_edges(t_op[i], t_y[i]));
         end
         checks++;
         if (r !== t_r[i]) begin errors++; $display("FAIL corner%0d_result got %h exp %h", i, r, t_r[i]); end
         checks++;
         if (f !== t_f[i]) begin errors++; $display("FAIL corner%0d_flags got %b exp %b", i, f, t_f[i]); end
         release_out();
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL corner%0d_release got ov=%b ir=%b exp ov=0 ir=1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_back_pressure();
      logic [WIDTH-1:0] x, y, r0, er;
      logic [3:0]       f0, ef;
      logic [WIDTH-1:0] r;
      logic [3:0]       f;
      int               lat;
      x = WIDTH'($urandom);
      y = WIDTH'($urandom);
      model(XOR, x, y, er, ef);
      run_op(XOR, x, y, lat, r0, f0);
      checks++;
      if (r0 !== er || f0 !== ef) begin
         errors++;
         $display("FAIL bp_xor got %h/%b exp %h/%b", r0, f0, er, ef);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         op = 3'($urandom);
         a  = WIDTH'($urandom);
         b  = WIDTH'($urandom);
         @(posedge clk);
         #1;
         checks++;
         if (result !== r0 || flags !== f0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold%0d got %h/%b ir=%b ov=%b exp %h/%b ir=0 ov=1",
                     i, result, flags, in_ready, out_valid, r0, f0);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      release_out();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
      end
      x = WIDTH'($urandom);
      y = WIDTH'($urandom);
      model(SUB, x, y, er, ef);
      run_op(SUB, x, y, lat, r, f);
      checks++;
      if (lat != 0 || r !== er || f !== ef) begin
         errors++;
         $display("FAIL bp_next_op got lat=%0d %h/%b exp lat=0 %h/%b", lat, r, f, er, ef);
      end
      release_out();
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] x1, y1, x2, y2, er1, er2;
      logic [3:0]       ef1, ef2;
      x1 = WIDTH'($urandom); y1 = WIDTH'($urandom);
      x2 = WIDTH'($urandom); y2 = WIDTH'($urandom);
      model(ADD, x1, y1, er1, ef1);
      model(XOR, x2, y2, er2, ef2);
      @(negedge clk);
      in_valid = 1'b1; op = ADD; a = x1; b = y1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || result !== er1 || flags !== ef1) begin
         errors++;
         $display("FAIL b2b_first got ov=%b %h/%b exp ov=1 %h/%b", out_valid, result, flags, er1, ef1);
      end
      op = XOR; a = x2; b = y2;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_only_output got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || result !== er2 || flags !== ef2) begin
         errors++;
         $display("FAIL b2b_second got ov=%b %h/%b exp ov=1 %h/%b", out_valid, result, flags, er2, ef2);
      end
      release_out();
   endtask

   task automatic test_random();
      logic [2:0]       o;
      logic [WIDTH-1:0] x, y, er, r;
      logic [3:0]       ef, f;
      int               lat, hold;
      bit               stable;
      for (int i = 0; i < 60; i++) begin
         o = 3'($urandom_range(0, 7));
         x = WIDTH'($urandom);
         y = WIDTH'($urandom);
         if ($urandom_range(0, 3) == 0) y = WIDTH'($urandom_range(0, 3));
         model(o, x, y, er, ef);
         run_op(o, x, y, lat, r, f);
         checks++;
         if (lat != exp_edges(o, y)) begin
            errors++;
            $display("FAIL rand%0d_latency op=%0d got %0d exp %0d", i, o, lat, exp_edges(o, y));
         end
         checks++;
         if (r !== er) begin
            errors++;
            $display("FAIL rand%0d_result op=%0d a=%h b=%h got %h exp %h", i, o, x, y, r, er);
         end
         checks++;
         if (f !== ef) begin
            errors++;
            $display("FAIL rand%0d_flags op=%0d a=%h b=%h got %b exp %b", i, o, x, y, f, ef);
         end
         hold   = $urandom_range(0, 3);
         stable = 1'b1;
         repeat (hold) begin
            @(posedge clk);
            #1;
            if (result !== r || flags !== f || out_valid !== 1'b1) stable = 1'b0;
         end
         checks++;
         if (!stable) begin errors++; $display("FAIL rand%0d_hold got unstable exp stable", i); end
         release_out();
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rand%0d_release got ov=%b ir=%b exp ov=0 ir=1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      bit stale;
      @(negedge clk);
      in_valid = 1'b1;
      op = FAST ? DIV : MUL;
      a  = WIDTH'($urandom) | WIDTH'(1);
      b  = WIDTH'($urandom) | WIDTH'(1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL midop_busy got ir=%b ov=%b exp ir=0 ov=0", in_ready, out_valid);
      end
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || flags !== 4'b0000) begin
         errors++;
         $display("FAIL midop_reset got ov=%b ir=%b %h/%b exp ov=0 ir=1 0/0000",
                  out_valid, in_ready, result, flags);
      end
      @(negedge clk);
      rst = 1'b0;
      stale = 1'b0;
      repeat (WIDTH + 4) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) stale = 1'b1;
      end
      checks++;
      if (stale) begin errors++; $display("FAIL midop_stale got output after reset exp none"); end
   endtask

   initial begin
      test_reset();
      test_corner_cases();
      test_back_pressure();
      test_back_to_back();
      test_random();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
